// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller and its time counter.
package stopwatch_pkg;

  // Display bus widths, shared with the seven-segment display driver.
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int CS_W  = 7;

  localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [CS_W-1:0]  cs;
  } time_t;

endpackage

// File: rtl/stopwatch_time_counter.sv
// Cascaded centisecond / second / minute counter with overflow handling.
// ovf is a combinational pulse marking the tick that steps past MAX_MIN:59.99.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN  = 59,
  parameter bit          SATURATE = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  output time_t value,
  output logic  ovf
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);

  logic at_max;

  assign at_max = (value == {MIN_TOP, SEC_MAX, CS_MAX});
  assign ovf    = en && !clr && at_max;

  // Advance the cascade on each enabled tick; clear wins over counting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which is what makes the carry chain correct.
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      if (at_max) begin
        if (!SATURATE) value <= '0;
      end else if (value.cs != CS_MAX) begin
        value.cs <= value.cs + 7'd1;
      end else begin
        value.cs <= '0;
        if (value.sec != SEC_MAX) begin
          value.sec <= value.sec + 6'd1;
        end else begin
          value.sec <= '0;
          value.min <= value.min + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Run/pause/lap/clear sequencer: owns the FSM, the lap-hold register and the
// registered display bus; the live time lives in stopwatch_time_counter.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN  = 59,
  parameter bit          SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_cs,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [6:0] centiseconds,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  state_t state;
  time_t  live;
  time_t  lap_q;
  logic   counting;
  logic   count_en;
  logic   count_clr;
  logic   ovf_pulse;

  // Counting follows the current state only, so a tick on the edge that
  // leaves RUN still counts and one on the edge that enters RUN is dropped.
  assign counting  = (state == ST_RUN) || (state == ST_LAP);
  assign count_en  = tick_cs && counting;
  assign count_clr = (state == ST_PAUSE) && btn_clear;

  stopwatch_time_counter #(
    .MAX_MIN  (MAX_MIN),
    .SATURATE (SATURATE)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (count_en),
    .clr   (count_clr),
    .value (live),
    .ovf   (ovf_pulse)
  );

  // Button sequencing (clear > start_stop > lap), lap capture and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_start_stop) state <= ST_RUN;
        end
        ST_RUN: begin
          if (btn_start_stop) begin
            state <= ST_PAUSE;
          end else if (btn_lap) begin
            state <= ST_LAP;
            lap_q <= live;  // pre-increment value, independent of a same-cycle tick
          end
        end
        ST_LAP: begin
          if (btn_start_stop) state <= ST_PAUSE;
          else if (btn_lap)   state <= ST_RUN;
        end
        ST_PAUSE: begin
          if (btn_clear)           state <= ST_IDLE;
          else if (btn_start_stop) state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase

      if (count_clr)      overflow <= 1'b0;
      else if (ovf_pulse) overflow <= 1'b1;
    end
  end

  // Registered display bus and status flags, one cycle behind state and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      minutes      <= '0;
      seconds      <= '0;
      centiseconds <= '0;
      running      <= 1'b0;
      lap_active   <= 1'b0;
    end else begin
      if (state == ST_LAP) begin
        minutes      <= lap_q.min;
        seconds      <= lap_q.sec;
        centiseconds <= lap_q.cs;
      end else begin
        minutes      <= live.min;
        seconds      <= live.sec;
        centiseconds <= live.cs;
      end
      running    <= counting;
      lap_active <= (state == ST_LAP);
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller: main instance with default limits
// plus two MAX_MIN=1 instances (saturating and wrapping) for overflow.
module tb_stopwatch_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance (MAX_MIN=59, SATURATE=1)
  logic       rst_n, tick, ss, lap, clr;
  logic [5:0] minutes, seconds;
  logic [6:0] centiseconds;
  logic       running, lap_active, overflow;
  logic [21:0] obs;
  assign obs = {minutes, seconds, centiseconds, running, lap_active, overflow};

  stopwatch_controller dut (
    .clk(clk), .rst_n(rst_n), .tick_cs(tick), .btn_start_stop(ss),
    .btn_lap(lap), .btn_clear(clr), .minutes(minutes), .seconds(seconds),
    .centiseconds(centiseconds), .running(running), .lap_active(lap_active),
    .overflow(overflow)
  );

  // Overflow instances share their own stimulus
  logic       rst5_n, tick5, ss5, zero5;
  logic [5:0] m1, s1, m0, s0;
  logic [6:0] c1, c0;
  logic       r1, l1, o1, r0, l0, o0;
  logic [21:0] obs1, obs0;
  assign obs1 = {m1, s1, c1, r1, l1, o1};
  assign obs0 = {m0, s0, c0, r0, l0, o0};

  stopwatch_controller #(.MAX_MIN(1), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst5_n), .tick_cs(tick5), .btn_start_stop(ss5),
    .btn_lap(zero5), .btn_clear(zero5), .minutes(m1), .seconds(s1),
    .centiseconds(c1), .running(r1), .lap_active(l1), .overflow(o1)
  );

  stopwatch_controller #(.MAX_MIN(1), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst5_n), .tick_cs(tick5), .btn_start_stop(ss5),
    .btn_lap(zero5), .btn_clear(zero5), .minutes(m0), .seconds(s0),
    .centiseconds(c0), .running(r0), .lap_active(l0), .overflow(o0)
  );

  // Stimulus is driven and sampled on the falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press(input logic p_ss, input logic p_lap, input logic p_clr);
    ss = p_ss; lap = p_lap; clr = p_clr;
    @(negedge clk);
    ss = 1'b0; lap = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_and_run();
    do_reset();
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.0 r0 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    press(1'b1, 1'b0, 1'b0);
    ticks(250);
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd2, 7'd50, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL run_250: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:2.50 r1 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
  endtask

  task automatic test_lap();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    ticks(123);
    press(1'b0, 1'b1, 1'b0);
    ticks(100);
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd1, 7'd23, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lap_hold: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:1.23 r1 l1 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    press(1'b0, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd2, 7'd23, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL lap_release: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:2.23 r1 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
  endtask

  task automatic test_tick_coincidence();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    ticks(5);
    tick = 1'b1;
    press(1'b1, 1'b0, 1'b0);  // RUN->PAUSE with tick: counted
    tick = 1'b0;
    ticks(50);
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd0, 7'd6, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pause_tick: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.06 r0 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    tick = 1'b1;
    press(1'b1, 1'b0, 1'b0);  // PAUSE->RUN with tick: dropped
    tick = 1'b0;
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd0, 7'd6, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL resume_tick: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.06 r1 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    ticks(1);
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd0, 7'd7, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL resume_count: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.07 r1 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    ticks(300);
    press(1'b0, 1'b0, 1'b1);  // clear ignored in RUN
    press(1'b1, 1'b1, 1'b0);  // start_stop beats lap
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd3, 7'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pause_3s: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:3.00 r0 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    press(1'b1, 1'b0, 1'b1);  // clear beats start_stop
    idle(2);
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL clear_idle: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.0 r0 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    ticks(5);
    idle(2);
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL idle_no_count: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.0 r0 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
  endtask

  task automatic test_overflow();
    rst5_n = 1'b0;
    idle(2);
    rst5_n = 1'b1;
    ss5 = 1'b1;
    idle(1);
    ss5 = 1'b0;
    tick5 = 1'b1;
    repeat (11999) @(negedge clk);
    tick5 = 1'b0;
    idle(2);
    checks++;
    if (obs1 !== {6'd1, 6'd59, 7'd99, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sat_preload: got %0d:%0d.%0d r%0b o%0b, expected 1:59.99 r1 o0", m1, s1, c1, r1, o1);
    end
    checks++;
    if (obs0 !== {6'd1, 6'd59, 7'd99, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_preload: got %0d:%0d.%0d r%0b o%0b, expected 1:59.99 r1 o0", m0, s0, c0, r0, o0);
    end
    tick5 = 1'b1;
    idle(1);
    tick5 = 1'b0;
    idle(2);
    checks++;
    if (obs1 !== {6'd1, 6'd59, 7'd99, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_hold: got %0d:%0d.%0d r%0b o%0b, expected 1:59.99 r1 o1", m1, s1, c1, r1, o1);
    end
    checks++;
    if (obs0 !== {6'd0, 6'd0, 7'd0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_zero: got %0d:%0d.%0d r%0b o%0b, expected 0:0.00 r1 o1", m0, s0, c0, r0, o0);
    end
    tick5 = 1'b1;
    idle(1);
    tick5 = 1'b0;
    idle(2);
    checks++;
    if (obs0 !== {6'd0, 6'd0, 7'd1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_continue: got %0d:%0d.%0d r%0b o%0b, expected 0:0.01 r1 o1", m0, s0, c0, r0, o0);
    end
    checks++;
    if (obs1 !== {6'd1, 6'd59, 7'd99, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_still: got %0d:%0d.%0d r%0b o%0b, expected 1:59.99 r1 o1", m1, s1, c1, r1, o1);
    end
  endtask

  task automatic test_reset_mid_lap();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    ticks(10);
    press(1'b0, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs !== {6'd0, 6'd0, 7'd10, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lap_entry: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.10 r1 l1 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    rst_n = 1'b0;
    tick  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick  = 1'b0;
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL reset_in_lap: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.0 r0 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
    ticks(5);
    idle(2);
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL reset_to_idle: got %0d:%0d.%0d r%0b l%0b o%0b, expected 0:0.0 r0 l0 o0",
               minutes, seconds, centiseconds, running, lap_active, overflow);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; ss = 1'b0; lap = 1'b0; clr = 1'b0;
    rst5_n = 1'b0; tick5 = 1'b0; ss5 = 1'b0; zero5 = 1'b0;
    idle(1);
    test_reset_and_run();
    test_lap();
    test_tick_coincidence();
    test_clear_priority();
    test_overflow();
    test_reset_mid_lap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
